// File: rtl/scene_stream_tx_if.sv
// Host byte stream and scene-loader bus of the voxel scene transmitter.
// master = the transmitter's view, slave = the host/loader environment.
interface scene_stream_tx_if #(
   parameter int ADDR_BITS = 15
);
   logic                 in_valid;
   logic                 in_ready;
   logic [7:0]           in_data;
   logic                 load_mode;
   logic                 load_valid;
   logic                 load_ready;
   logic [ADDR_BITS-1:0] load_addr;
   logic                 load_data;

   modport master (
      input  in_valid,
      input  in_data,
      input  load_ready,
      output in_ready,
      output load_mode,
      output load_valid,
      output load_addr,
      output load_data
   );

   modport slave (
      output in_valid,
      output in_data,
      output load_ready,
      input  in_ready,
      input  load_mode,
      input  load_valid,
      input  load_addr,
      input  load_data
   );
endinterface

// File: rtl/scene_stream_tx.sv
// Serializes packed occupancy bytes into one voxel bit per loader handshake at sequential addresses.
// Optional macro SCENE_STREAM_TX_POPCOUNT_EN adds the ones_count checksum output.
module scene_stream_tx #(
   parameter int          ADDR_BITS = 15,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_BITS:0]   num_voxels,
   scene_stream_tx_if.master    bus,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_BITS:0]   sent_count
`ifdef SCENE_STREAM_TX_POPCOUNT_EN
   ,
   output logic [ADDR_BITS:0]   ones_count
`endif
);

   localparam logic [ADDR_BITS-1:0] BASE = BASE_ADDR[ADDR_BITS-1:0];

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      STREAM,
      FINISH
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [ADDR_BITS:0]   num_reg;
   logic [ADDR_BITS:0]   sent_next;
   logic [ADDR_BITS-1:0] addr;
   logic [7:0]           shift;
   logic [2:0]           bit_idx;
   logic                 accept_start;
   logic                 byte_hs;
   logic                 load_hs;
   logic                 in_ready_c;
   logic                 load_valid_c;
   logic                 active_c;

   assign sent_next = sent_count + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Handshake qualifiers come straight from the state so that the bus
   // outputs never depend combinationally on in_valid or load_ready.
   always_comb begin
      state_next   = state;
      in_ready_c   = 1'b0;
      load_valid_c = 1'b0;
      active_c     = 1'b1;
      accept_start = 1'b0;
      byte_hs      = 1'b0;
      load_hs      = 1'b0;
      case (state)
         IDLE: begin
            active_c     = 1'b0;
            accept_start = start;
            if (start) begin
               state_next = (num_voxels == '0) ? FINISH : FETCH;
            end
         end
         FETCH: begin
            in_ready_c = 1'b1;
            byte_hs    = bus.in_valid;
            if (bus.in_valid) begin
               state_next = STREAM;
            end
         end
         STREAM: begin
            load_valid_c = 1'b1;
            load_hs      = bus.load_ready;
            if (bus.load_ready) begin
               if (sent_next == num_reg) begin
                  state_next = FINISH;
               end else if (bit_idx == 3'd7) begin
                  state_next = FETCH;
               end
            end
         end
         FINISH: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            active_c   = 1'b0;
         end
      endcase
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.load_valid = load_valid_c;
   assign bus.load_mode  = active_c;
   assign bus.load_addr  = addr;
   assign bus.load_data  = shift[bit_idx];
   assign busy           = active_c;

   // Transfer datapath: counters restart on an accepted start and advance
   // only on a completed loader handshake, so stalls never skip a bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         num_reg    <= '0;
         sent_count <= '0;
         addr       <= '0;
         shift      <= '0;
         bit_idx    <= '0;
         done       <= 1'b0;
      end else begin
         done <= (state == FINISH);
         if (accept_start) begin
            num_reg    <= num_voxels;
            sent_count <= '0;
            addr       <= BASE;
         end
         if (byte_hs) begin
            shift   <= bus.in_data;
            bit_idx <= '0;
         end
         if (load_hs) begin
            sent_count <= sent_next;
            addr       <= addr + 1'b1;
            bit_idx    <= bit_idx + 1'b1;
         end
      end
   end

`ifdef SCENE_STREAM_TX_POPCOUNT_EN
   // Running count of occupied voxels actually delivered to the loader.
   always_ff @(posedge clk) begin
      if (rst) begin
         ones_count <= '0;
      end else if (accept_start) begin
         ones_count <= '0;
      end else if (load_hs && bus.load_data) begin
         ones_count <= ones_count + 1'b1;
      end
   end
`endif

endmodule
